bus_arbiter: RTL

//  Shares one Wishbone-style single-port memory bus between instruction fetch (IF, driven by
//  pc_reg's pc/ce) and data access (MEM stage). Sequences one transaction at a time. Raises

---
 rtl/bus_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Single-port Wishbone-style bus arbiter shared by instruction fetch and the MEM stage.
// Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic              flush,
   input  logic              if_ce,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stallreq,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [3:0]        mem_sel,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_stallreq,
   output logic              bus_cyc,
   output logic              bus_stb,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              bus_err
);

   typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

   state_t            state, state_n;
   logic              cyc, cyc_n;
   logic              we, we_n;
   logic [3:0]        sel, sel_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [DATA_W-1:0] wdata, wdata_n;
   logic              if_done, if_done_n;
   logic              mem_done, mem_done_n;
   logic              discard, discard_n;
   logic [DATA_W-1:0] if_hold, if_hold_n;
   logic [DATA_W-1:0] mem_hold, mem_hold_n;
   logic              err, err_n;
   logic              timeout;
   logic              finish;
   logic [DATA_W-1:0] finish_data;
   logic              unused_stall;

   assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

`ifdef BUS_TIMEOUT_EN
   logic [3:0] cnt, cnt_n;

   // Watchdog counts busy cycles; counter is zero on the first busy cycle.
   assign timeout = (state != IDLE) && !bus_ack && (cnt == 4'(TIMEOUT - 1));

   always_comb begin
      cnt_n = cnt + 4'd1;
      if (state == IDLE || finish)
         cnt_n = 4'd0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= 4'd0;
      else
         cnt <= cnt_n;
   end
`else
   logic [31:0] unused_timeout;

   assign unused_timeout = TIMEOUT;
   assign timeout        = 1'b0;
`endif

   // A timed-out transaction completes like an ack but delivers zero data.
   assign finish      = (state != IDLE) && (bus_ack || timeout);
   assign finish_data = bus_ack ? bus_rdata : '0;

   always_comb begin
      state_n    = state;
      cyc_n      = cyc;
      we_n       = we;
      sel_n      = sel;
      addr_n     = addr;
      wdata_n    = wdata;
      discard_n  = discard;
      if_hold_n  = if_hold;
      mem_hold_n = mem_hold;
      err_n      = timeout;
      if_done_n  = if_done;
      mem_done_n = mem_done;

      case (state)
         IDLE: begin
            discard_n = 1'b0;
            if (mem_req && !mem_done) begin
               state_n = MEM_BUSY;
               cyc_n   = 1'b1;
               we_n    = mem_we;
               sel_n   = mem_sel;
               addr_n  = mem_addr;
               wdata_n = mem_wdata;
            end else if (if_ce && !if_done && !flush) begin
               state_n = IF_BUSY;
               cyc_n   = 1'b1;
               we_n    = 1'b0;
               sel_n   = 4'hF;
               addr_n  = if_addr;
               wdata_n = '0;
            end
         end
         IF_BUSY: begin
            if (finish) begin
               state_n   = IDLE;
               cyc_n     = 1'b0;
               we_n      = 1'b0;
               discard_n = 1'b0;
               if (!discard && !flush)
                  if_hold_n = finish_data;
            end else if (flush) begin
               discard_n = 1'b1;
            end
         end
         MEM_BUSY: begin
            if (finish) begin
               state_n    = IDLE;
               cyc_n      = 1'b0;
               we_n       = 1'b0;
               mem_hold_n = finish_data;
            end
         end
         default: begin
            state_n = IDLE;
            cyc_n   = 1'b0;
         end
      endcase

      // A flush always discards the fetch result; otherwise a completion beats a same-edge clear.
      if (flush)
         if_done_n = 1'b0;
      else if (state == IF_BUSY && finish && !discard)
         if_done_n = 1'b1;
      else if (!stall[1])
         if_done_n = 1'b0;

      if (state == MEM_BUSY && finish)
         mem_done_n = 1'b1;
      else if (!stall[4])
         mem_done_n = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cyc      <= 1'b0;
         we       <= 1'b0;
         sel      <= 4'h0;
         addr     <= '0;
         wdata    <= '0;
         if_done  <= 1'b0;
         mem_done <= 1'b0;
         discard  <= 1'b0;
         if_hold  <= '0;
         mem_hold <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         cyc      <= cyc_n;
         we       <= we_n;
         sel      <= sel_n;
         addr     <= addr_n;
         wdata    <= wdata_n;
         if_done  <= if_done_n;
         mem_done <= mem_done_n;
         discard  <= discard_n;
         if_hold  <= if_hold_n;
         mem_hold <= mem_hold_n;
         err      <= err_n;
      end
   end

   assign bus_cyc      = cyc;
   assign bus_stb      = cyc;
   assign bus_we       = we;
   assign bus_sel      = sel;
   assign bus_addr     = addr;
   assign bus_wdata    = wdata;
   assign bus_err      = err;
   assign if_rdata     = if_hold;
   assign mem_rdata    = mem_hold;
   assign if_stallreq  = if_ce & ~if_done;
   assign mem_stallreq = mem_req & ~mem_done;

endmodule
